// File: rtl/wb_burst_master.sv
// Wishbone master issuing single or incrementing-burst cycles, one command at a time.
// Optional WB_TIMEOUT_EN aborts a beat after TIMEOUT_CYCLES without wb_ack_i.
module wb_burst_master #(
  parameter int unsigned dw             = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic            sys_clk,
  input  logic            RESETN,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_we,
  input  logic [25:0]     cmd_addr,
  input  logic [3:0]      cmd_len,
  input  logic            wr_valid,
  output logic            wr_ready,
  input  logic [dw-1:0]   wr_data,
  input  logic [dw/8-1:0] wr_sel,
  output logic            rd_valid,
  output logic [dw-1:0]   rd_data,
  output logic            done,
  output logic            error,
  output logic            busy,
  output logic            wb_cyc_o,
  output logic            wb_stb_o,
  output logic            wb_we_o,
  output logic [25:0]     wb_addr_o,
  output logic [dw-1:0]   wb_dat_o,
  output logic [dw/8-1:0] wb_sel_o,
  output logic [2:0]      wb_cti_o,
  input  logic            wb_ack_i,
  input  logic [dw-1:0]   wb_dat_i
);
  localparam logic [2:0] CtiIncr = 3'b010;
  localparam logic [2:0] CtiEnd  = 3'b111;

  typedef enum logic [1:0] {StIdle, StWfetch, StBus, StFinish} state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              cyc_q, cyc_d;
  logic              stb_q, stb_d;
  logic              we_q, we_d;
  logic [25:0]       addr_q, addr_d;
  logic [dw-1:0]     dat_q, dat_d;
  logic [dw/8-1:0]   sel_q, sel_d;
  logic [2:0]        cti_q, cti_d;
  logic              rd_valid_q, rd_valid_d;
  logic [dw-1:0]     rd_data_q, rd_data_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic              busy_q, busy_d;
  logic              wr_ready_q, wr_ready_d;
  logic              timeout_hit;

`ifdef WB_TIMEOUT_EN
  localparam int unsigned ToW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [ToW-1:0] to_cnt_q, to_cnt_d;

  // Counts un-acked strobe cycles of the current beat; any ack or idle bus clears it.
  always_comb begin
    to_cnt_d = '0;
    if (stb_q && !wb_ack_i) to_cnt_d = to_cnt_q + 1'b1;
  end

  assign timeout_hit = stb_q && !wb_ack_i && (to_cnt_q == ToW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge sys_clk or negedge RESETN) begin
    if (!RESETN) to_cnt_q <= '0;
    else         to_cnt_q <= to_cnt_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cyc_d      = cyc_q;
    stb_d      = stb_q;
    we_d       = we_q;
    addr_d     = addr_q;
    dat_d      = dat_q;
    sel_d      = sel_q;
    cti_d      = cti_q;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    done_d     = 1'b0;
    error_d    = 1'b0;
    busy_d     = busy_q;
    wr_ready_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          we_d   = cmd_we;
          addr_d = cmd_addr;
          cnt_d  = cmd_len;
          cti_d  = (cmd_len == 4'd0) ? CtiEnd : CtiIncr;
          busy_d = 1'b1;
          if (cmd_we) begin
            wr_ready_d = 1'b1;
            state_d    = StWfetch;
          end else begin
            cyc_d   = 1'b1;
            stb_d   = 1'b1;
            state_d = StBus;
          end
        end
      end
      StWfetch: begin
        wr_ready_d = 1'b1;
        if (wr_valid) begin
          dat_d      = wr_data;
          sel_d      = wr_sel;
          cyc_d      = 1'b1;
          stb_d      = 1'b1;
          wr_ready_d = 1'b0;
          state_d    = StBus;
        end
      end
      StBus: begin
        if (timeout_hit) begin
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          busy_d  = 1'b0;
          error_d = 1'b1;
          state_d = StFinish;
        end else if (wb_ack_i) begin
          if (!we_q) begin
            rd_valid_d = 1'b1;
            rd_data_d  = wb_dat_i;
          end
          if (cnt_q == 4'd0) begin
            cyc_d   = 1'b0;
            stb_d   = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = StFinish;
          end else begin
            cnt_d  = cnt_q - 4'd1;
            addr_d = addr_q + 26'd1;
            cti_d  = (cnt_q == 4'd1) ? CtiEnd : CtiIncr;
            // Writes keep cyc high but drop stb while the next beat is fetched.
            if (we_q) begin
              stb_d      = 1'b0;
              wr_ready_d = 1'b1;
              state_d    = StWfetch;
            end
          end
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge sys_clk or negedge RESETN) begin
    if (!RESETN) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      cyc_q      <= 1'b0;
      stb_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      dat_q      <= '0;
      sel_q      <= '0;
      cti_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      busy_q     <= 1'b0;
      wr_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cyc_q      <= cyc_d;
      stb_q      <= stb_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      dat_q      <= dat_d;
      sel_q      <= sel_d;
      cti_q      <= cti_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      done_q     <= done_d;
      error_q    <= error_d;
      busy_q     <= busy_d;
      wr_ready_q <= wr_ready_d;
    end
  end

  // Gated by RESETN so it reads 0 while reset is held and 1 as soon as it releases.
  assign cmd_ready = (state_q == StIdle) && RESETN;
  assign wr_ready  = wr_ready_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign done      = done_q;
  assign error     = error_q;
  assign busy      = busy_q;
  assign wb_cyc_o  = cyc_q;
  assign wb_stb_o  = stb_q;
  assign wb_we_o   = we_q;
  assign wb_addr_o = addr_q;
  assign wb_dat_o  = dat_q;
  assign wb_sel_o  = sel_q;
  assign wb_cti_o  = cti_q;

endmodule

// File: tb/tb_wb_burst_master.sv
// Scoreboard bench for wb_burst_master: commands push expected beats, read data and
// completions into queues; a negedge monitor plays the slave and pops/compares.
module tb_wb_burst_master;
  localparam int unsigned Dw       = 32;
  localparam int unsigned ToCycles = 8;

  logic            sys_clk = 1'b0;
  logic            RESETN = 1'b0;
  logic            cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
  logic [25:0]     cmd_addr = '0;
  logic [3:0]      cmd_len = '0;
  logic            wr_valid = 1'b0, wr_ready;
  logic [Dw-1:0]   wr_data = '0;
  logic [Dw/8-1:0] wr_sel = '0;
  logic            rd_valid, done, error, busy;
  logic [Dw-1:0]   rd_data;
  logic            wb_cyc_o, wb_stb_o, wb_we_o, wb_ack_i = 1'b0;
  logic [25:0]     wb_addr_o;
  logic [Dw-1:0]   wb_dat_o, wb_dat_i = '0;
  logic [Dw/8-1:0] wb_sel_o;
  logic [2:0]      wb_cti_o;

  always #5 sys_clk = ~sys_clk;

  wb_burst_master #(.dw(Dw), .TIMEOUT_CYCLES(ToCycles)) dut (
    .sys_clk(sys_clk), .RESETN(RESETN),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_sel(wr_sel),
    .rd_valid(rd_valid), .rd_data(rd_data), .done(done), .error(error), .busy(busy),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_addr_o(wb_addr_o),
    .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_cti_o(wb_cti_o),
    .wb_ack_i(wb_ack_i), .wb_dat_i(wb_dat_i)
  );

  typedef struct packed {
    logic [25:0] addr;
    logic [2:0]  cti;
    logic        we;
    logic [31:0] dat;
    logic [3:0]  sel;
  } beat_t;

  beat_t       exp_beat_q[$];
  logic [31:0] exp_rd_q[$];
  int          exp_done = 0, exp_err = 0;
  int          errors = 0, checks = 0;
  int          cyc_cnt = 0, done_cyc = 0, stb_cycles = 0;
  int          slave_wait = 0, wait_left = 0;
  bit          slave_rand = 1'b0, slave_never_ack = 1'b0, beat_active = 1'b0;
  beat_t       held;

  function automatic logic [31:0] mem_word(input logic [25:0] a);
    return ({6'd0, a} * 32'd2654435761) ^ 32'hC0DE_0000;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge sys_clk) cyc_cnt++;

  // Slave responder plus scoreboard monitor, sampled mid-cycle.
  always @(negedge sys_clk) begin
    beat_t cur, exp;
    wb_ack_i = 1'b0;
    if (RESETN) begin
      if (wb_stb_o) begin
        stb_cycles++;
        check("cyc_with_stb", wb_cyc_o, 1'b1);
        cur.addr = wb_addr_o;
        cur.cti  = wb_cti_o;
        cur.we   = wb_we_o;
        cur.dat  = wb_we_o ? wb_dat_o : '0;
        cur.sel  = wb_we_o ? wb_sel_o : '0;
        if (!beat_active) begin
          checks++;
          if (exp_beat_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_beat: got addr 0x%0h, expected no beat", wb_addr_o);
          end else begin
            exp = exp_beat_q.pop_front();
            check("beat_addr", cur.addr, exp.addr);
            check("beat_cti", cur.cti, exp.cti);
            check("beat_we", cur.we, exp.we);
            check("beat_dat", cur.dat, exp.dat);
            check("beat_sel", cur.sel, exp.sel);
          end
          beat_active = 1'b1;
          held = cur;
          wait_left = slave_rand ? $urandom_range(slave_wait, 0) : slave_wait;
        end else begin
          check("beat_stable", cur === held, 1'b1);
        end
        if (!slave_never_ack) begin
          if (wait_left == 0) begin
            wb_ack_i = 1'b1;
            wb_dat_i = mem_word(wb_addr_o);
            beat_active = 1'b0;
          end else begin
            wait_left--;
          end
        end
      end
      if (rd_valid) begin
        checks++;
        if (exp_rd_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_rd: got 0x%0h, expected no read data", rd_data);
        end else begin
          check("rd_data", rd_data, exp_rd_q.pop_front());
        end
      end
      if (done) begin
        done_cyc = cyc_cnt;
        check("done_expected", exp_done > 0, 1'b1);
        check("done_bus_idle", {wb_cyc_o, wb_stb_o, error}, 3'b000);
        if (exp_done > 0) exp_done--;
      end
      if (error) begin
        check("error_expected", exp_err > 0, 1'b1);
        check("error_bus_idle", {wb_cyc_o, wb_stb_o, done}, 3'b000);
        if (exp_err > 0) exp_err--;
      end
    end
  end

  task automatic issue_cmd(input bit we, input logic [25:0] addr, input int len,
                           output int acc_cyc);
    int to;
    to = 0;
    cmd_we = we; cmd_addr = addr; cmd_len = 4'(len); cmd_valid = 1'b1;
    @(negedge sys_clk);
    while (!cmd_ready && to < 50) begin
      to++;
      @(negedge sys_clk);
    end
    check("cmd_ready_wait", cmd_ready, 1'b1);
    @(posedge sys_clk); #1;
    cmd_valid = 1'b0;
    acc_cyc = cyc_cnt;
    check("busy_after_accept", busy, 1'b1);
    check("cmd_ready_after_accept", cmd_ready, 1'b0);
    check("stb_after_accept", wb_stb_o, !we);
    check("wr_ready_after_accept", wr_ready, we);
  endtask

  task automatic run_cmd(input bit we, input logic [25:0] addr, input int len,
                         input int stall_beat, input int stall_cyc, input int wait_max,
                         input bit wait_rand, input bit use_first,
                         input logic [31:0] first_dat, input logic [3:0] first_sel);
    logic [31:0] wd[$];
    logic [3:0]  ws[$];
    int          acc_cyc, to;
    slave_wait = wait_max;
    slave_rand = wait_rand;
    for (int i = 0; i <= len; i++) begin
      beat_t b;
      b.addr = addr + 26'(i);  // 26-bit arithmetic gives the wrap
      b.cti  = (i == len) ? 3'b111 : 3'b010;
      b.we   = we;
      b.dat  = '0;
      b.sel  = '0;
      if (we) begin
        b.dat = (use_first && i == 0) ? first_dat : $urandom;
        b.sel = (use_first && i == 0) ? first_sel : 4'($urandom_range(15, 1));
      end
      wd.push_back(b.dat);
      ws.push_back(b.sel);
      exp_beat_q.push_back(b);
      if (!we) exp_rd_q.push_back(mem_word(b.addr));
    end
    exp_done++;
    issue_cmd(we, addr, len, acc_cyc);
    if (we) begin
      for (int i = 0; i <= len; i++) begin
        if (i == stall_beat && stall_cyc > 0) begin
          wr_valid = 1'b0;
          repeat (stall_cyc) @(posedge sys_clk);
          #1;
          check("stall_cyc", wb_cyc_o, i > 0);
          check("stall_stb", wb_stb_o, 1'b0);
        end
        wr_valid = 1'b1; wr_data = wd[i]; wr_sel = ws[i];
        to = 0;
        @(negedge sys_clk);
        while (!wr_ready && to < 100) begin
          to++;
          @(negedge sys_clk);
        end
        check("wr_ready_wait", wr_ready, 1'b1);
        @(posedge sys_clk); #1;
        wr_valid = 1'b0;
      end
      // Offer a surplus beat; it must never be taken.
      wr_valid = 1'b1; wr_data = 32'hBAD0_BAD0; wr_sel = 4'hF;
    end
    to = 0;
    while (exp_done != 0 && to < 2000) begin
      @(posedge sys_clk);
      to++;
    end
    #1;
    check("done_seen", exp_done, 0);
    if (wait_max == 0 && stall_cyc == 0)
      check("latency", done_cyc - acc_cyc, we ? 2 * (len + 1) : len + 1);
    check("idle_after_done", {cmd_ready, busy, wr_ready, wb_cyc_o, wb_stb_o}, 5'b10000);
    check("beats_left", exp_beat_q.size(), 0);
    check("rd_left", exp_rd_q.size(), 0);
    wr_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int    acc;
    beat_t b;
    bit    we;
    logic [25:0] addr;
    int    len, sbeat, scyc, wmax;

    #12;
    check("rst_cmd_ready", cmd_ready, 1'b0);
    check("rst_ctrl", {busy, done, error, rd_valid, wr_ready}, 5'b0);
    check("rst_bus", {wb_cyc_o, wb_stb_o, wb_we_o, wb_cti_o}, 6'b0);
    check("rst_addr", wb_addr_o, 0);
    check("rst_dat_sel", {wb_dat_o, wb_sel_o}, 0);
    check("rst_rd_data", rd_data, 0);
    @(negedge sys_clk);
    RESETN = 1'b1;
    #1;
    check("cmd_ready_after_release", cmd_ready, 1'b1);
    @(posedge sys_clk); #1;

    // Directed cases from the plan.
    run_cmd(1'b1, 26'h10, 0, 0, 0, 0, 1'b0, 1'b1, 32'hDEAD_BEEF, 4'hF);
    run_cmd(1'b0, 26'hFC, 3, 0, 0, 0, 1'b0, 1'b0, '0, '0);
    run_cmd(1'b1, 26'h200, 2, 1, 5, 0, 1'b0, 1'b0, '0, '0);
    run_cmd(1'b0, 26'h40, 1, 0, 0, 3, 1'b0, 1'b0, '0, '0);
    run_cmd(1'b0, 26'h3FF_FFFF, 1, 0, 0, 0, 1'b0, 1'b0, '0, '0);
    run_cmd(1'b1, 26'h3FF_FFFE, 3, 0, 0, 0, 1'b0, 1'b0, '0, '0);

    // Reset in the middle of a stalled read beat.
    slave_wait = 10; slave_rand = 1'b0;
    b = '{addr: 26'h123, cti: 3'b010, we: 1'b0, dat: '0, sel: '0};
    exp_beat_q.push_back(b);
    issue_cmd(1'b0, 26'h123, 3, acc);
    repeat (2) @(posedge sys_clk);
    #3;
    check("stb_before_reset", wb_stb_o, 1'b1);
    RESETN = 1'b0;
    #1;
    check("midrst_bus", {wb_cyc_o, wb_stb_o, busy, cmd_ready}, 4'b0);
    check("midrst_addr_cti", {wb_addr_o, wb_cti_o}, 0);
    exp_beat_q.delete(); exp_rd_q.delete(); exp_done = 0; beat_active = 1'b0;
    @(negedge sys_clk);
    RESETN = 1'b1;
    #1;
    check("cmd_ready_after_midrst", cmd_ready, 1'b1);
    slave_wait = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge sys_clk);
      check("no_done_after_reset", {done, busy}, 2'b00);
    end
    @(posedge sys_clk); #1;

`ifdef WB_TIMEOUT_EN
    slave_never_ack = 1'b1;
    b = '{addr: 26'h2000, cti: 3'b010, we: 1'b0, dat: '0, sel: '0};
    exp_beat_q.push_back(b);
    exp_err++;
    stb_cycles = 0;
    issue_cmd(1'b0, 26'h2000, 3, acc);
    for (int i = 0; i < 100 && exp_err != 0; i++) @(posedge sys_clk);
    #1;
    check("error_seen", exp_err, 0);
    check("timeout_stb_cycles", stb_cycles, ToCycles);
    slave_never_ack = 1'b0;
    beat_active = 1'b0;
    run_cmd(1'b0, 26'h2100, 2, 0, 0, 0, 1'b0, 1'b0, '0, '0);
`endif

    // Randomized traffic.
    for (int n = 0; n < 20; n++) begin
      we = 1'($urandom);
      if ($urandom_range(3, 0) == 0) addr = 26'h3FF_FFFF - 26'($urandom_range(3, 0));
      else addr = 26'($urandom);
      len   = $urandom_range(15, 0);
      sbeat = $urandom_range(len, 0);
      scyc  = ($urandom_range(2, 0) == 0) ? $urandom_range(4, 1) : 0;
      wmax  = $urandom_range(3, 0);
      run_cmd(we, addr, len, sbeat, scyc, wmax, 1'b1, 1'b0, '0, '0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
